// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 front-end types and constants
package mips_pkg;

    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    // One prefetch-queue slot: the instruction word tagged with its fetch PC
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - fetch unit memory, redirect and decode handshake bundle
interface mips_fetch_unit_if #(
    parameter int ADDR_W = 14
);
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst;
    logic [31:0]       inst_pc;
    logic              inst_ready;

    // Fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    // Memory / branch unit / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parametrised synchronous FIFO with flush
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    // Empty FIFO reads as zero so the head is well defined straight out of reset
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush discards everything held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - decoupled MIPS32 fetch stage; optional FETCH_PERF_EN perf counters
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    mips_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] tag_count;
    logic             q_empty;
    logic             q_full;
    logic             tag_empty;
    logic             tag_full;
    logic [31:0]      tag_pc;
    logic             credit;
    logic             req_fire;
    logic             rsp;
    logic             keep_rsp;
    logic             deq;
    fetch_entry_t     q_wdata;
    fetch_entry_t     head;
    logic             unused_ok;

    // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow
    assign credit   = ({1'b0, q_count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
    assign bus.imem_req_valid = !rst && !bus.redirect && credit;
    assign bus.imem_req_addr  = fetch_pc[ADDR_W-1:0];
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    assign rsp      = bus.imem_rsp_valid;
    assign keep_rsp = rsp && !bus.redirect && (drop == '0);
    assign q_wdata  = '{pc: tag_pc, inst: bus.imem_rsp_data};

    assign bus.inst_valid = !bus.redirect && !q_empty;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
    assign deq            = bus.inst_valid && bus.inst_ready;

    // Tags are never flushed: stale responses still arrive and must pop theirs
    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (req_fire),
        .wdata (fetch_pc),
        .pop   (rsp),
        .rdata (tag_pc),
        .empty (tag_empty),
        .full  (tag_full),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_prefetch_q (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (keep_rsp),
        .wdata (q_wdata),
        .pop   (deq),
        .rdata (head),
        .empty (q_empty),
        .full  (q_full),
        .count (q_count)
    );

    // Fetch PC, in-flight and drop bookkeeping; a redirect re-derives drop from inflight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + {{(CNT_W-1){1'b0}}, req_fire} - {{(CNT_W-1){1'b0}}, rsp};
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                drop     <= inflight - {{(CNT_W-1){1'b0}}, rsp};
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + PC_INC;
                if (rsp && drop != '0)
                    drop <= drop - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Decode starvation (saturating) and redirect counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.inst_ready && !bus.inst_valid && !bus.redirect && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
            if (bus.redirect)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

    assign unused_ok = &{1'b0, tag_empty, tag_full, tag_count, q_full, bus.redirect_pc[1:0]};
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - scoreboard bench for mips_fetch_unit
module tb_mips_fetch_unit;
    logic clk;
    logic rst;

    mips_fetch_unit_if #(.ADDR_W(14)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    mips_fetch_unit #(.ADDR_W(14), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [13:0] addr;
    } mreq_t;

    mreq_t       pend[$];
    logic [63:0] sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_count = 0;
    int          first_cons = -1;
    int          last_cons = -1;
    logic        last_req_valid;
    logic [13:0] last_req_addr;
    logic        last_inst_valid;

    function automatic logic [31:0] mem_word(logic [13:0] a);
        return 32'hC0DE_0000 | {18'b0, a};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_pc(logic [31:0] pc);
        sb.push_back({pc, mem_word(pc[13:0])});
    endtask

    // One clock cycle: memory model drives, outputs sampled #1 later, then wait next negedge
    task automatic step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mreq_t m;
            m = pend.pop_front();
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(m.addr);
        end
        #1;
        last_req_valid  = bus.imem_req_valid;
        last_req_addr   = bus.imem_req_addr;
        last_inst_valid = bus.inst_valid;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{cyc + lat, bus.imem_req_addr});
            acc_count++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            if (first_cons < 0) first_cons = cyc;
            last_cons = cyc;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_inst: observed pc %h expected no output", bus.inst_pc);
            end
            if (sb.size() > 0) begin
                logic [63:0] e;
                e = sb.pop_front();
                check("inst_pc", bus.inst_pc, e[63:32]);
                check("inst", bus.inst, e[31:0]);
            end
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        cyc++;
    endtask

    task automatic run_until_empty(int bound);
        int n;
        n = 0;
        while (sb.size() > 0 && n < bound) begin
            step();
            n++;
        end
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic do_redirect(logic [31:0] pc);
        bus.redirect    = 1'b1;
        bus.redirect_pc = pc;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect       = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.inst_ready     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_inst_pc", bus.inst_pc, 0);

        // Sustained stream from RESET_PC with 1-cycle memory
        for (int i = 0; i < 8; i++) expect_pc(32'(4 * i));
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        cyc = 0;
        step();
        check("a_first_req_valid", last_req_valid, 1);
        check("a_first_req_addr", last_req_addr, 0);
        run_until_empty(40);
        check("a_first_valid_cycle", first_cons, 2);
        check("a_back_to_back", last_cons - first_cons, 7);

        // Backpressure: only DEPTH requests accepted, then one request per pop
        bus.inst_ready = 1'b0;
        do_redirect(32'h0000_0040);
        acc_count = 0;
        repeat (12) step();
        check("b_accepted", acc_count, 4);
        check("b_req_stopped", last_req_valid, 0);
        for (int i = 0; i < 8; i++) expect_pc(32'h40 + 32'(4 * i));
        bus.inst_ready = 1'b1;
        step();
        check("b_no_req_full", last_req_valid, 0);
        step();
        check("b_req_after_pop", last_req_valid, 1);
        run_until_empty(40);
        bus.inst_ready = 1'b0;

        // 3-cycle memory, 3 in flight, redirect coinciding with first stale response
        bus.imem_req_ready = 1'b0;
        do_redirect(32'h0000_0200);
        repeat (4) step();
        lat = 3;
        bus.imem_req_ready = 1'b1;
        acc_count = 0;
        repeat (3) step();
        check("c_inflight", acc_count, 3);
        for (int i = 0; i < 6; i++) expect_pc(32'h100 + 32'(4 * i));
        bus.inst_ready = 1'b1;
        do_redirect(32'h0000_0103);
        step();
        check("c_req_valid", last_req_valid, 1);
        check("c_req_addr", last_req_addr, 14'h100);
        run_until_empty(60);
        bus.inst_ready = 1'b0;

        // Redirect while queue holds entries, a response arrives and decode is ready
        lat = 2;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(32'h300 + 32'(4 * i));
        do_redirect(32'h0000_0300);
        run_until_empty(40);
        for (int i = 0; i < 6; i++) expect_pc(32'h500 + 32'(4 * i));
        do_redirect(32'h0000_0500);
        check("d_redirect_void", last_inst_valid, 0);
        run_until_empty(60);
        bus.inst_ready = 1'b0;

        // Address wrap and request-address truncation
        lat = 1;
        bus.inst_ready = 1'b1;
        expect_pc(32'hFFFF_FFF8);
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        expect_pc(32'h0000_0004);
        do_redirect(32'hFFFF_FFF8);
        step();
        check("e_req_addr0", last_req_addr, 14'h3FF8);
        step();
        check("e_req_addr1", last_req_addr, 14'h3FFC);
        run_until_empty(40);
        bus.inst_ready = 1'b0;

`ifdef FETCH_PERF_EN
        begin
            logic [31:0] f0;
            logic [31:0] s0;
            f0 = flush_cnt;
            bus.inst_ready = 1'b1;
            bus.imem_req_ready = 1'b0;
            do_redirect(32'h0000_0600);
            do_redirect(32'h0000_0700);
            repeat (3) step();
            s0 = stall_cnt;
            repeat (5) step();
            check("p_stall_cnt", stall_cnt - s0, 5);
            check("p_flush_cnt", flush_cnt - f0, 2);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Parametrised instruction-fetch stage for the MIPS32 core, replacing the combinational `instructions[pc[13:2]]` lookup with a decoupled front end. It owns the fetch PC and issues word requests to a variable-latency instruction memory. Returned words are buffered in a DEPTH-entry prefetch queue and presented to decode through a valid/ready handshake. Branch, jump and `jr` targets arrive as a redirect that flushes all queued and in-flight fetches.

## Interface
Parameters:
- ADDR_W, 14, instruction-memory byte-address width (16 kB default)
- DEPTH, 4, prefetch queue entries, power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  word-aligned byte address, equal to fetch_pc[ADDR_W-1:0]
- imem_req_ready  in  1  memory accepts the request this cycle
- imem_rsp_valid  in  1  read data valid; responses are returned in request order, at most one per cycle
- imem_rsp_data  in  32  instruction word
- redirect  in  1  one-cycle pulse carrying a new fetch target
- redirect_pc  in  32  target address; bits [1:0] are ignored
- inst_valid  out  1  queue head valid
- inst  out  32  queue-head instruction
- inst_pc  out  32  PC of the queue-head instruction
- inst_ready  in  1  decode consumes the head this cycle

## Operation
- **State:**
  - fetch_pc (32 bit)
  - inflight counter, 0..DEPTH
  - drop counter, 0..DEPTH
  - queue of {pc, inst} entries with rd/wr pointers and count
- **Request credit:** imem_req_valid = !redirect && (count + inflight < DEPTH). The queue can therefore never overflow.
- **Request accepted** (req_valid && req_ready):
  - inflight +1
  - fetch_pc += 4, modulo 2^32
  - the accepted PC is pushed to a pc-tag FIFO of DEPTH entries, in order.
- **Response:**
  - If drop > 0: the response is discarded and drop −1.
  - Otherwise it is enqueued with its PC tag.
  - In both cases inflight −1 and the tag is popped.
- **Dequeue:** inst_valid && inst_ready pops the head.
- **Redirect cycle:**
  - Queue is flushed (count=0).
  - drop = inflight − (response this cycle ? 1 : 0).
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No request is issued and inst_valid = 0, so the consumer handshake is void.
  - A response arriving in the same cycle is discarded.
  - Fetching resumes the next cycle.
- **Back-to-back redirects:** the last one wins; drop accumulates correctly because it is recomputed from inflight each time.
- **Simultaneous enqueue and dequeue** is legal at any count, including DEPTH.
- **Address wrap:** fetch_pc wrapping from 32'hFFFF_FFFC to 0 is legal. imem_req_addr silently truncates to ADDR_W bits.

## Timing
- **Reset values:**
  - imem_req_valid 0, imem_req_addr RESET_PC[ADDR_W-1:0]
  - inst_valid 0, inst 0, inst_pc 0
  - all counters 0, fetch_pc = RESET_PC
- **First request:** imem_req_valid rises in the first cycle after rst deasserts.
- **Response to inst_valid:** 1 cycle; the queue is registered and has no bypass.
- **Redirect to first new request:** 1 cycle. Redirect to first valid instruction: 1 + memory latency + 1.
- **Throughput:** sustained 1 instruction/cycle with single-cycle memory and DEPTH ≥ 2.
- **Reset mid-operation:** all state clears immediately. Responses to pre-reset requests arriving after reset are outside the contract; the memory must also be reset.

## Configuration
- **FETCH_PERF_EN defined:**
  - Adds output `stall_cnt` (out, 32): counts cycles with inst_ready=1 && inst_valid=0 && !redirect. Saturating, reset 0.
  - Adds output `flush_cnt` (out, 32): counts redirect pulses. Wrapping, reset 0.
- **FETCH_PERF_EN undefined:** neither port nor any counter logic exists.

## Structure
- **Shared package `mips_pkg`:**
  - INST_W=32
  - NOP_INST=32'h0000_0000
  - the fetch-entry struct {pc[31:0], inst[31:0]}
  - the PC increment constant 4
- **Sub-module:** `fetch_fifo`, a parametrised synchronous FIFO with a flush input.
  - Instantiated twice: once for the pc-tag FIFO, once for the prefetch queue.

## Test plan
- **Reset, 1-cycle memory, inst_ready=1:** requests at 0,4,8,… on consecutive cycles. inst_valid from cycle 2, and inst_pc increments by 4 every cycle.
- **inst_ready=0, DEPTH=4:** exactly 4 requests are accepted, then imem_req_valid=0. Raising inst_ready resumes requests one per pop.
- **3-cycle memory, 3 in flight, redirect to 32'h0000_0103:**
  - the 3 stale responses are dropped
  - next request addr = 0x100
  - first inst_pc = 0x100
- **Redirect coinciding with a response and a dequeue:** queue empties, that response is discarded, and nothing from the old path ever appears.
- **Redirect to 32'hFFFF_FFF8:** inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. imem_req_addr is truncated to ADDR_W bits.
- **FETCH_PERF_EN:**
  - 5 empty-queue cycles with inst_ready=1 give stall_cnt=5.
  - 2 redirects give flush_cnt=2.
